// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - two-requester byte-transfer arbiter driving the simple_spi_top Wishbone bus
// Optional poll timeout with FIFO flush is enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter logic [7:0] SPCR_INIT     = 8'h50,
    parameter logic [7:0] SPER_INIT     = 8'h00,
    parameter int         TIMEOUT_POLLS = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req0_i,
    input  logic [7:0] req0_data_i,
    output logic       ack0_o,
    input  logic       req1_i,
    input  logic [7:0] req1_data_i,
    output logic       ack1_o,
    output logic [7:0] rx_data_o,
    output logic       err_o,
    output logic       grant_o,
    output logic       busy_o,
    output logic       m_cyc_o,
    output logic       m_stb_o,
    output logic       m_we_o,
    output logic [7:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    input  logic       m_ack_i
);

    typedef enum logic [2:0] {
        INIT_SPER,
        INIT_SPCR,
        IDLE,
        WR_DAT,
        POLL,
        RD_DAT,
        DONE
    } state_t;

    localparam logic [7:0] ADR_SPCR = 8'd0;
    localparam logic [7:0] ADR_SPSR = 8'd1;
    localparam logic [7:0] ADR_SPDR = 8'd2;
    localparam logic [7:0] ADR_SPER = 8'd3;

    state_t     state_q, state_d;
    logic       stb_q, stb_d;
    logic       we_q, we_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       grant_q, grant_d;

    logic       want;
    logic       want_we;
    logic [7:0] want_adr;
    logic [7:0] want_dat;
    logic       acc_done;

`ifdef SPI_XFER_TIMEOUT_EN
    localparam logic [7:0] POLL_LIMIT = 8'(TIMEOUT_POLLS);
    logic [7:0] polls_q, polls_d;
    logic       err_q, err_d;
    logic       flush_q, flush_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_POLLS;
`endif

    assign acc_done = stb_q && m_ack_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= INIT_SPER;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 8'd0;
            wdat_q  <= 8'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            grant_q <= 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
            polls_q <= 8'd0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            grant_q <= grant_d;
`ifdef SPI_XFER_TIMEOUT_EN
            polls_q <= polls_d;
            err_q   <= err_d;
            flush_q <= flush_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        grant_d  = grant_q;
        want     = 1'b0;
        want_we  = 1'b0;
        want_adr = 8'd0;
        want_dat = 8'd0;
`ifdef SPI_XFER_TIMEOUT_EN
        polls_d  = polls_q;
        err_d    = err_q;
        flush_d  = flush_q;
`endif

        case (state_q)
            INIT_SPER: begin
                want     = 1'b1;
                want_we  = 1'b1;
                want_adr = ADR_SPER;
                want_dat = SPER_INIT;
                if (acc_done) state_d = INIT_SPCR;
            end
            INIT_SPCR: begin
                want     = 1'b1;
                want_we  = 1'b1;
                want_adr = ADR_SPCR;
                want_dat = SPCR_INIT;
                if (acc_done) state_d = IDLE;
            end
            IDLE: begin
                // On contention the requester not served last wins.
                if (req0_i && (!req1_i || grant_q)) begin
                    grant_d = 1'b0;
                    tx_d    = req0_data_i;
                    state_d = WR_DAT;
                end else if (req1_i) begin
                    grant_d = 1'b1;
                    tx_d    = req1_data_i;
                    state_d = WR_DAT;
                end
`ifdef SPI_XFER_TIMEOUT_EN
                if (req0_i || req1_i) begin
                    polls_d = 8'd0;
                    err_d   = 1'b0;
                end
`endif
            end
            WR_DAT: begin
                want     = 1'b1;
                want_adr = ADR_SPDR;
`ifdef SPI_XFER_TIMEOUT_EN
                // A byte that arrived after a timeout is drained before the next write.
                if (flush_q) begin
                    if (acc_done) flush_d = 1'b0;
                end else begin
                    want_we  = 1'b1;
                    want_dat = tx_q;
                    if (acc_done) state_d = POLL;
                end
`else
                want_we  = 1'b1;
                want_dat = tx_q;
                if (acc_done) state_d = POLL;
`endif
            end
            POLL: begin
                want     = 1'b1;
                want_adr = ADR_SPSR;
                if (acc_done) begin
                    if (!m_dat_i[0]) begin
                        state_d = RD_DAT;
                    end
`ifdef SPI_XFER_TIMEOUT_EN
                    else begin
                        polls_d = polls_q + 8'd1;
                        if (polls_q + 8'd1 == POLL_LIMIT) begin
                            rx_d    = 8'hFF;
                            err_d   = 1'b1;
                            flush_d = 1'b1;
                            state_d = DONE;
                        end
                    end
`endif
                end
            end
            RD_DAT: begin
                want     = 1'b1;
                want_adr = ADR_SPDR;
                if (acc_done) begin
                    rx_d    = m_dat_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_SPER;
            end
        endcase

        // Strobe holds until acked, then is low for one cycle before the next access.
        if (stb_q) begin
            stb_d = !m_ack_i;
        end else if (want) begin
            stb_d  = 1'b1;
            we_d   = want_we;
            adr_d  = want_adr;
            wdat_d = want_dat;
        end
    end

    assign m_cyc_o   = stb_q;
    assign m_stb_o   = stb_q;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;
    assign rx_data_o = rx_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
    assign ack0_o    = (state_q == DONE) && !grant_q;
    assign ack1_o    = (state_q == DONE) && grant_q;
`ifdef SPI_XFER_TIMEOUT_EN
    assign err_o     = (state_q == DONE) && err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - directed scoreboard bench for spi_xfer_arbiter with a modelled SPI register slave
module tb_spi_xfer_arbiter;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       req0_i = 1'b0, req1_i = 1'b0;
    logic [7:0] req0_data_i = 8'h00, req1_data_i = 8'h00;
    logic       ack0_o, ack1_o, err_o, grant_o, busy_o;
    logic [7:0] rx_data_o;
    logic       m_cyc_o, m_stb_o, m_we_o, m_ack_i;
    logic [7:0] m_adr_o, m_dat_o, m_dat_i;

    spi_xfer_arbiter #(
        .SPCR_INIT(8'h50), .SPER_INIT(8'h00), .TIMEOUT_POLLS(4)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req0_i(req0_i), .req0_data_i(req0_data_i), .ack0_o(ack0_o),
        .req1_i(req1_i), .req1_data_i(req1_data_i), .ack1_o(ack1_o),
        .rx_data_o(rx_data_o), .err_o(err_o), .grant_o(grant_o), .busy_o(busy_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed { logic we; logic [7:0] adr; logic [7:0] dat; } acc_t;
    typedef struct packed { logic idx; logic [7:0] rx; logic err; } ack_t;

    acc_t       acc_q[$];
    logic [7:0] rd_q[$];
    ack_t       ack_q[$];
    int         checks = 0, errors = 0;
    int         ack_count = 0, cyc = 0, hold0 = 0, hold1 = 0;
    int         ack_cyc[0:63];
    logic       stall_poll = 1'b0, prev_acc = 1'b0, model_grant = 1'b1;
    logic [7:0] rd_cur = 8'h00;
    acc_t       mon_acc;
    ack_t       mon_ack;

    // Slave acks in the strobe cycle unless told to stall SPSR reads.
    assign m_ack_i = m_stb_o && !(stall_poll && !m_we_o && m_adr_o == 8'd1);
    assign m_dat_i = rd_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge wb_clk_i) cyc++;

    always @(negedge wb_clk_i) begin
        if (cyc > 0) begin
            if (m_stb_o === 1'b1 && m_ack_i === 1'b1) begin
                chk("idle_gap", prev_acc, 1'b0);
                chk("cyc_eq_stb", m_cyc_o, 1'b1);
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", acc_q.size(), 1);
                end else begin
                    mon_acc = acc_q.pop_front();
                    chk("bus_we", m_we_o, mon_acc.we);
                    chk("bus_adr", m_adr_o, mon_acc.adr);
                    if (mon_acc.we) chk("bus_wdat", m_dat_o, mon_acc.dat);
                end
                if (!m_we_o) rd_cur = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                prev_acc = 1'b1;
            end else begin
                prev_acc = 1'b0;
            end
            if (ack0_o === 1'b1 || ack1_o === 1'b1) begin
                if (ack_count < 64) ack_cyc[ack_count] = cyc;
                ack_count++;
                chk("ack_both", ack0_o & ack1_o, 1'b0);
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", ack_q.size(), 1);
                end else begin
                    mon_ack = ack_q.pop_front();
                    chk("ack_idx", ack1_o, mon_ack.idx);
                    chk("ack_rx", rx_data_o, mon_ack.rx);
                    chk("ack_err", err_o, mon_ack.err);
                end
                if (ack0_o && hold0 > 0) begin
                    hold0--;
                    if (hold0 == 0) req0_i = 1'b0;
                end
                if (ack1_o && hold1 > 0) begin
                    hold1--;
                    if (hold1 == 0) req1_i = 1'b0;
                end
            end else begin
                chk("err_idle", err_o, 1'b0);
            end
        end
    end

    task automatic push_init();
        acc_q.push_back('{we: 1'b1, adr: 8'd3, dat: 8'h00});
        acc_q.push_back('{we: 1'b1, adr: 8'd0, dat: 8'h50});
    endtask

    task automatic expect_xfer(input logic idx, input logic [7:0] tx, input int busy_polls,
                               input logic [7:0] rx, input logic flush);
        if (flush) begin
            acc_q.push_back('{we: 1'b0, adr: 8'd2, dat: 8'h00});
            rd_q.push_back(8'hEE);
        end
        acc_q.push_back('{we: 1'b1, adr: 8'd2, dat: tx});
        for (int i = 0; i < busy_polls; i++) begin
            acc_q.push_back('{we: 1'b0, adr: 8'd1, dat: 8'h00});
            rd_q.push_back(8'h05);
        end
        acc_q.push_back('{we: 1'b0, adr: 8'd1, dat: 8'h00});
        rd_q.push_back(8'h04);
        acc_q.push_back('{we: 1'b0, adr: 8'd2, dat: 8'h00});
        rd_q.push_back(rx);
        ack_q.push_back('{idx: idx, rx: rx, err: 1'b0});
        model_grant = idx;
    endtask

    task automatic wait_acks(input int target, input int limit);
        int n = 0;
        while (ack_count < target && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("ack_wait", ack_count, target);
        @(negedge wb_clk_i);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy_o !== 1'b0 && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("idle_wait", busy_o, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first;
        int   n;

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", busy_o, 1'b1);
        chk("rst_stb", m_stb_o, 1'b0);
        chk("rst_we", m_we_o, 1'b0);
        chk("rst_adr", m_adr_o, 8'd0);
        chk("rst_dat", m_dat_o, 8'd0);
        chk("rst_grant", grant_o, 1'b1);
        chk("rst_ack", {ack0_o, ack1_o}, 2'b00);
        chk("rst_rx", rx_data_o, 8'd0);
        push_init();
        wb_rst_i = 1'b0;
        wait_idle(50);
        repeat (10) @(negedge wb_clk_i);
        chk("init_drained", acc_q.size(), 0);
        chk("idle_quiet", m_stb_o, 1'b0);

        // Both request together; requester 0 first, minimum latency
        first = ~model_grant;
        expect_xfer(first, first ? 8'h22 : 8'h11, 0, 8'hC3, 1'b0);
        expect_xfer(~first, first ? 8'h11 : 8'h22, 0, 8'h5E, 1'b0);
        req0_data_i = 8'h11; req1_data_i = 8'h22;
        hold0 = 1; hold1 = 1;
        req0_i = 1'b1; req1_i = 1'b1;
        n = 0;
        while (ack0_o !== 1'b1 && ack1_o !== 1'b1 && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("min_latency", n, 7);
        wait_acks(2, 200);

        // Both again: alternation continues
        first = ~model_grant;
        expect_xfer(first, first ? 8'h44 : 8'h33, 1, 8'h66, 1'b0);
        expect_xfer(~first, first ? 8'h33 : 8'h44, 0, 8'h99, 1'b0);
        req0_data_i = 8'h33; req1_data_i = 8'h44;
        hold0 = 1; hold1 = 1;
        req0_i = 1'b1; req1_i = 1'b1;
        wait_acks(4, 200);

        // Single requester 0 with two busy polls
        expect_xfer(1'b0, 8'hA5, 2, 8'h3C, 1'b0);
        req0_data_i = 8'hA5; hold0 = 1; req0_i = 1'b1;
        wait_acks(5, 200);
        chk("grant_after_req0", grant_o, 1'b0);

        // Requester 1 held for three back-to-back transfers
        for (int i = 0; i < 3; i++) expect_xfer(1'b1, 8'h7E, 0, 8'h10 + 8'(i), 1'b0);
        req1_data_i = 8'h7E; hold1 = 3; req1_i = 1'b1;
        wait_acks(8, 300);
        chk("b2b_gap_a", ack_cyc[6] - ack_cyc[5], 8);
        chk("b2b_gap_b", ack_cyc[7] - ack_cyc[6], 8);

        // Reset while a poll is stalled on the bus
        acc_q.push_back('{we: 1'b1, adr: 8'd2, dat: 8'h5A});
        stall_poll = 1'b1;
        req0_data_i = 8'h5A; req0_i = 1'b1;
        n = 0;
        while (!(m_stb_o === 1'b1 && m_adr_o == 8'd1 && m_we_o === 1'b0) && n < 50) begin
            @(negedge wb_clk_i);
            n++;
        end
        repeat (2) @(negedge wb_clk_i);
        chk("poll_held", m_stb_o, 1'b1);
        wb_rst_i = 1'b1;
        req0_i = 1'b0; hold0 = 0;
        @(negedge wb_clk_i);
        chk("rst_mid_stb", m_stb_o, 1'b0);
        chk("rst_mid_ack", ack0_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b1);
        push_init();
        model_grant = 1'b1;
        wb_rst_i = 1'b0;
        stall_poll = 1'b0;
        wait_idle(50);
        expect_xfer(1'b0, 8'h5A, 0, 8'hA1, 1'b0);
        hold0 = 1; req0_i = 1'b1;
        wait_acks(9, 200);

`ifdef SPI_XFER_TIMEOUT_EN
        // Poll timeout, then a flushed transfer
        acc_q.push_back('{we: 1'b1, adr: 8'd2, dat: 8'h77});
        for (int i = 0; i < 4; i++) begin
            acc_q.push_back('{we: 1'b0, adr: 8'd1, dat: 8'h00});
            rd_q.push_back(8'h05);
        end
        ack_q.push_back('{idx: 1'b0, rx: 8'hFF, err: 1'b1});
        req0_data_i = 8'h77; hold0 = 1; req0_i = 1'b1;
        wait_acks(10, 200);
        expect_xfer(1'b1, 8'h88, 0, 8'h42, 1'b1);
        req1_data_i = 8'h88; hold1 = 1; req1_i = 1'b1;
        wait_acks(11, 200);
`endif

        repeat (10) @(negedge wb_clk_i);
        chk("acc_q_empty", acc_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("ack_q_empty", ack_q.size(), 0);
        chk("final_busy", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
